// File: rtl/mult_seq.sv
// Sequential shift-add multiplier: captures operand magnitudes on start, runs WIDTH
// add/shift iterations, then applies the product sign in a single fix-up cycle.
module mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_signed_mode,
  input  logic [WIDTH-1:0]     i_x,
  input  logic [WIDTH-1:0]     i_y,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state, w_state_next;
  logic [WIDTH-1:0]     r_a, w_a_next;
  logic [WIDTH-1:0]     r_mq, w_mq_next;
  logic [WIDTH-1:0]     r_m, w_m_next;
  logic                 r_neg, w_neg_next;
  logic [CW-1:0]        r_cnt, w_cnt_next;
  logic                 r_busy, w_busy_next;
  logic                 r_done, w_done_next;
  logic [2*WIDTH-1:0]   r_product, w_product_next;

  logic [WIDTH-1:0]     w_x_mag, w_y_mag, w_addend;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_raw;

  // The magnitude of the most negative value still fits in WIDTH bits unsigned.
  assign w_x_mag  = (i_signed_mode && i_x[WIDTH-1]) ? -i_x : i_x;
  assign w_y_mag  = (i_signed_mode && i_y[WIDTH-1]) ? -i_y : i_y;
  assign w_addend = r_mq[0] ? r_m : '0;
  assign w_sum    = {1'b0, r_a} + {1'b0, w_addend};
  assign w_raw    = {r_a, r_mq};

  always_comb begin
    w_state_next   = r_state;
    w_a_next       = r_a;
    w_mq_next      = r_mq;
    w_m_next       = r_m;
    w_neg_next     = r_neg;
    w_cnt_next     = r_cnt;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;
    w_product_next = r_product;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_m_next     = w_x_mag;
          w_mq_next    = w_y_mag;
          w_neg_next   = i_signed_mode & (i_x[WIDTH-1] ^ i_y[WIDTH-1]);
          w_a_next     = '0;
          w_cnt_next   = '0;
          w_busy_next  = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        // Carry out of the add drops into the top of A as the pair shifts right.
        w_a_next   = w_sum[WIDTH:1];
        w_mq_next  = {w_sum[0], r_mq[WIDTH-1:1]};
        w_cnt_next = r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_state_next = S_FIX;
        end
      end
      S_FIX: begin
        w_product_next = r_neg ? -w_raw : w_raw;
        w_done_next    = 1'b1;
        w_busy_next    = 1'b0;
        w_state_next   = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_mq      <= '0;
      r_m       <= '0;
      r_neg     <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_state   <= w_state_next;
      r_a       <= w_a_next;
      r_mq      <= w_mq_next;
      r_m       <= w_m_next;
      r_neg     <= w_neg_next;
      r_cnt     <= w_cnt_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_product <= w_product_next;
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_product = r_product;

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq at WIDTH 4/8/16/32: a per-instance behavioural model checked every
// cycle, directed 8-bit cases with literal products, and a randomized operand sweep.
module tb_mult_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [3:0]        st_v = '0;
  logic [3:0]        sm_v = '0;
  logic [3:0][63:0]  x_v  = '0;
  logic [3:0][63:0]  y_v  = '0;
  logic [3:0]        busy_v, done_v;
  logic [3:0][63:0]  prod_v;

  function automatic int wof(int i);
    return (i == 0) ? 4 : (i == 1) ? 8 : (i == 2) ? 16 : 32;
  endfunction

  function automatic logic [63:0] mask_w(int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference: true (signed or unsigned) product reduced modulo 2^(2w).
  function automatic logic [63:0] ref_mul(logic [63:0] a, logic [63:0] b, logic sm, int w);
    logic [63:0] ea, eb;
    ea = a & mask_w(w);
    eb = b & mask_w(w);
    if (sm && ea[w-1]) ea = ea | ~mask_w(w);
    if (sm && eb[w-1]) eb = eb | ~mask_w(w);
    return (ea * eb) & mask_w(2 * w);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_inst
    localparam int W = (gi == 0) ? 4 : (gi == 1) ? 8 : (gi == 2) ? 16 : 32;
    logic           w_busy, w_done;
    logic [2*W-1:0] w_prod;
    logic           m_busy, m_done;
    logic [63:0]    m_prod, m_pend;
    int             m_rem;

    mult_seq #(.WIDTH(W)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (st_v[gi]),
      .i_signed_mode(sm_v[gi]),
      .i_x          (x_v[gi][W-1:0]),
      .i_y          (y_v[gi][W-1:0]),
      .o_busy       (w_busy),
      .o_done       (w_done),
      .o_product    (w_prod)
    );

    assign busy_v[gi] = w_busy;
    assign done_v[gi] = w_done;
    assign prod_v[gi] = 64'(w_prod);

    // Model: an accepted request yields its result W+1 edges later; idle otherwise.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_busy <= 1'b0;
        m_done <= 1'b0;
        m_prod <= '0;
        m_pend <= '0;
        m_rem  <= 0;
      end else begin
        m_done <= 1'b0;
        if (m_rem > 1) begin
          m_rem <= m_rem - 1;
        end else if (m_rem == 1) begin
          m_rem  <= 0;
          m_prod <= m_pend;
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end else if (st_v[gi]) begin
          m_pend <= ref_mul(x_v[gi], y_v[gi], sm_v[gi], W);
          m_rem  <= W + 1;
          m_busy <= 1'b1;
        end
      end
    end

    always @(negedge clk) begin
      check($sformatf("w%0d_busy", W), 64'(w_busy), 64'(m_busy));
      check($sformatf("w%0d_done", W), 64'(w_done), 64'(m_done));
      check($sformatf("w%0d_product", W), 64'(w_prod), m_prod);
    end
  end

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic sm, input logic s);
    x_v[1]  = 64'(a);
    y_v[1]  = 64'(b);
    sm_v[1] = sm;
    st_v[1] = s;
  endtask

  task automatic wait_done8(input string nm, input logic [63:0] exp, input int exp_busy);
    int bc = 0;
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done_v[1]) got = 1'b1;
      else if (busy_v[1]) bc++;
    end
    check({nm, "_seen"}, 64'(got), 64'd1);
    check(nm, prod_v[1], exp);
    check({nm, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                     input logic [63:0] exp, input string nm);
    @(posedge clk); #2 drive8(a, b, sm, 1'b1);
    @(posedge clk); #2 st_v[1] = 1'b0;
    wait_done8(nm, exp, 9);
  endtask

  function automatic logic [63:0] pick(int w);
    case ($urandom % 8)
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return mask_w(w);
      3:       return 64'd1 << (w - 1);
      4:       return mask_w(w) >> 1;
      default: return {$urandom, $urandom} & mask_w(w);
    endcase
  endfunction

  initial begin
    int dn;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy8", 64'(busy_v[1]), 64'd0);
    check("reset_done8", 64'(done_v[1]), 64'd0);
    check("reset_product32", prod_v[3], 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    op8(8'h06, 8'h0D, 1'b0, 64'h004E, "u_6x13");
    op8(8'hFD, 8'h05, 1'b1, 64'hFFF1, "s_m3x5");
    op8(8'hFF, 8'hFF, 1'b0, 64'hFE01, "u_ffxff");
    op8(8'hFF, 8'hFF, 1'b1, 64'h0001, "s_ffxff");
    op8(8'h80, 8'h80, 1'b1, 64'h4000, "s_80x80");
    op8(8'h80, 8'h7F, 1'b1, 64'hC080, "s_80x7f");
    op8(8'h00, 8'h80, 1'b1, 64'h0000, "s_0x80");

    // Start pulsed at E3 while busy must be ignored.
    @(posedge clk); #2 drive8(8'h06, 8'h0D, 1'b0, 1'b1);
    @(posedge clk); #2 st_v[1] = 1'b0;
    @(posedge clk);
    @(posedge clk); #2 drive8(8'hFF, 8'hFF, 1'b1, 1'b1);
    @(posedge clk); #2 st_v[1] = 1'b0;
    wait_done8("busy_ignore", 64'h004E, 6);
    dn = 0;
    repeat (15) begin
      @(negedge clk);
      if (done_v[1]) dn++;
    end
    check("busy_ignore_extra_done", 64'(dn), 64'd0);

    // Start held high with operands changing every cycle.
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #2 drive8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end
    @(posedge clk); #2 st_v[1] = 1'b0;
    repeat (12) @(posedge clk);

    // Asynchronous reset in the middle of an operation.
    @(posedge clk); #2 drive8(8'h55, 8'h33, 1'b0, 1'b1);
    @(posedge clk); #2 st_v[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("pre_reset_busy", 64'(busy_v[1]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy_v[1]), 64'd0);
    check("abort_done", 64'(done_v[1]), 64'd0);
    check("abort_product", prod_v[1], 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    op8(8'h07, 8'h09, 1'b0, 64'h003F, "after_reset_7x9");

    // Randomized sweep on all widths, including corner operands.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      for (int i = 0; i < 4; i++) begin
        st_v[i] = ($urandom % 3 == 0);
        sm_v[i] = 1'($urandom);
        x_v[i]  = pick(wof(i));
        y_v[i]  = pick(wof(i));
      end
    end
    @(posedge clk); #2 st_v = '0;
    repeat (40) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
